// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared constants and types for the MIPS pipeline slice around the ID/EX
// register: datapath widths, ALU op encoding, forwarding-select encoding and
// the bundle of control bits carried into EX.
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  // One-bit ALU op: the EX-stage ALU only distinguishes add from subtract.
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  // Which source a forwarding mux picked.
  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_REG = 2'd0;
  localparam fwd_sel_t FWD_MEM = 2'd1;
  localparam fwd_sel_t FWD_WB  = 2'd2;

  // Control bits that a bubble must clear.
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
  } ex_ctrl_t;

endpackage

// File: rtl/fwd_unit.sv
// -----------------------------------------------------------------------------
// fwd_unit
// Purely combinational RAW-forwarding mux for one source register.
//   src_i            register number being read in EX
//   reg_data_i       value read from the register file in ID (registered)
//   mem_*_i          EX/MEM writer: write enable, destination, result
//   wb_*_i           MEM/WB writer: write enable, destination, data
//   sel_o            which source was chosen (FWD_REG / FWD_MEM / FWD_WB)
//   data_o           forwarded operand
// The younger EX/MEM result wins over MEM/WB. Register 0 is hard-wired to
// zero, so a write to it must never be forwarded.
// -----------------------------------------------------------------------------
module fwd_unit #(
  parameter int DATA_W     = mips_pkg::DATA_W,
  parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] src_i,
  input  logic [DATA_W-1:0]     reg_data_i,
  input  logic                  mem_reg_write_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic [DATA_W-1:0]     mem_data_i,
  input  logic                  wb_reg_write_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic [DATA_W-1:0]     wb_data_i,
  output mips_pkg::fwd_sel_t    sel_o,
  output logic [DATA_W-1:0]     data_o
);
  import mips_pkg::*;

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_reg_write_i & (mem_rd_i != '0) & (mem_rd_i == src_i);
  assign wb_hit  = wb_reg_write_i  & (wb_rd_i  != '0) & (wb_rd_i  == src_i);

  always_comb begin
    sel_o  = FWD_REG;
    data_o = reg_data_i;
    if (mem_hit) begin
      sel_o  = FWD_MEM;
      data_o = mem_data_i;
    end else if (wb_hit) begin
      sel_o  = FWD_WB;
      data_o = wb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register plus operand delivery for the EX-stage ALU.
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   id_*                   decoded operands, register numbers and control
//   flush                  branch taken: the instruction entering EX is killed
//   mem_*, wb_*            EX/MEM and MEM/WB writers used for forwarding
//   stall                  load-use hazard: hold PC and IF/ID (combinational)
//   alu_a, alu_b           forwarded ALU operands (combinational)
//   alu_control, ex_*      registered op, control and destination for EX/MEM
//   ex_store_data          forwarded rt value for stores
//   ex_imm                 registered immediate for the branch target
//   fwd_a_sel, fwd_b_sel   debug view of the rs / rt forwarding selects
//
// Valid semantics: ex_valid marks a real instruction in EX. There is no
// back-pressure from EX; stall only tells upstream to hold while this stage
// inserts a bubble (ex_valid = 0 with all side-effect controls cleared).
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W     = mips_pkg::DATA_W,
  parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_alu_src,
  input  logic                  id_alu_ctrl,
  input  logic                  id_reg_dst,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_mem_to_reg,
  input  logic                  id_branch,
  input  logic                  flush,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0]     mem_alu_result,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  stall,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic                  alu_control,
  output logic                  ex_valid,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_branch,
  output logic [REG_ADDR_W-1:0] ex_write_reg,
  output logic [DATA_W-1:0]     ex_store_data,
  output logic [DATA_W-1:0]     ex_imm,
  output mips_pkg::fwd_sel_t    fwd_a_sel,
  output mips_pkg::fwd_sel_t    fwd_b_sel
);
  import mips_pkg::*;

  ex_ctrl_t              ctrl_d, ctrl_q;
  logic [REG_ADDR_W-1:0] write_reg_d, write_reg_q;
  logic [REG_ADDR_W-1:0] rs_q, rt_q;
  logic [DATA_W-1:0]     rs_data_q, rt_data_q, imm_q;
  logic                  alu_src_q, alu_ctrl_q;
  logic [DATA_W-1:0]     fwd_rs_data, fwd_rt_data;

  // Load-use: the value of a load in EX is not available for forwarding until
  // it leaves MEM. The rt compare is conservative (I-type rt is a destination).
  assign stall = ctrl_q.valid & ctrl_q.mem_read & (write_reg_q != '0) & id_valid &
                 ((write_reg_q == id_rs) | (write_reg_q == id_rt));

  // Flush and stall both produce a bubble, so their relative priority only
  // matters in that both clear the controls.
  always_comb begin
    ctrl_d = '0;
    if (!flush && !stall && id_valid) begin
      ctrl_d = '{valid:      1'b1,
                 reg_write:  id_reg_write,
                 mem_read:   id_mem_read,
                 mem_write:  id_mem_write,
                 mem_to_reg: id_mem_to_reg,
                 branch:     id_branch};
    end
  end

  assign write_reg_d = id_reg_dst ? id_rd : id_rt;

  // Datapath fields are captured every cycle; under a bubble they are
  // don't-care because the controls are already cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q      <= '0;
      write_reg_q <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
      alu_ctrl_q  <= ALU_ADD;
    end else begin
      ctrl_q      <= ctrl_d;
      write_reg_q <= write_reg_d;
      rs_q        <= id_rs;
      rt_q        <= id_rt;
      rs_data_q   <= id_rs_data;
      rt_data_q   <= id_rt_data;
      imm_q       <= id_imm;
      alu_src_q   <= id_alu_src;
      alu_ctrl_q  <= id_alu_ctrl;
    end
  end

  fwd_unit #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
    .src_i           (rs_q),
    .reg_data_i      (rs_data_q),
    .mem_reg_write_i (mem_reg_write),
    .mem_rd_i        (mem_rd),
    .mem_data_i      (mem_alu_result),
    .wb_reg_write_i  (wb_reg_write),
    .wb_rd_i         (wb_rd),
    .wb_data_i       (wb_data),
    .sel_o           (fwd_a_sel),
    .data_o          (fwd_rs_data)
  );

  fwd_unit #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
    .src_i           (rt_q),
    .reg_data_i      (rt_data_q),
    .mem_reg_write_i (mem_reg_write),
    .mem_rd_i        (mem_rd),
    .mem_data_i      (mem_alu_result),
    .wb_reg_write_i  (wb_reg_write),
    .wb_rd_i         (wb_rd),
    .wb_data_i       (wb_data),
    .sel_o           (fwd_b_sel),
    .data_o          (fwd_rt_data)
  );

  assign alu_a         = fwd_rs_data;
  assign alu_b         = alu_src_q ? imm_q : fwd_rt_data;
  assign ex_store_data = fwd_rt_data;
  assign alu_control   = alu_ctrl_q;
  assign ex_valid      = ctrl_q.valid;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_branch     = ctrl_q.branch;
  assign ex_write_reg  = write_reg_q;
  assign ex_imm        = imm_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import mips_pkg::*;

  localparam int EXP_W = 140;

  typedef struct packed {
    logic        valid;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        alu_src;
    logic        alu_ctrl;
    logic        reg_dst;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch;
  } id_t;

  logic        clk, rst_n;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_alu_src, id_alu_ctrl, id_reg_dst;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
  logic        flush;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic [31:0] mem_alu_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall;
  logic [31:0] alu_a, alu_b;
  logic        alu_control;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
  logic [4:0]  ex_write_reg;
  logic [31:0] ex_store_data, ex_imm;
  fwd_sel_t    fwd_a_sel, fwd_b_sel;

  int total = 0;
  int bad   = 0;
  logic [EXP_W-1:0] exp_q[$];

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alu_src(id_alu_src), .id_alu_ctrl(id_alu_ctrl), .id_reg_dst(id_reg_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch), .flush(flush),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_alu_result(mem_alu_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
    .ex_write_reg(ex_write_reg), .ex_store_data(ex_store_data), .ex_imm(ex_imm),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checks happen 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  function automatic id_t nop_id();
    id_t t;
    t = '0;
    return t;
  endfunction

  task automatic apply_id(input id_t t);
    id_valid      = t.valid;
    id_rs_data    = t.rs_data;
    id_rt_data    = t.rt_data;
    id_imm        = t.imm;
    id_rs         = t.rs;
    id_rt         = t.rt;
    id_rd         = t.rd;
    id_alu_src    = t.alu_src;
    id_alu_ctrl   = t.alu_ctrl;
    id_reg_dst    = t.reg_dst;
    id_reg_write  = t.reg_write;
    id_mem_read   = t.mem_read;
    id_mem_write  = t.mem_write;
    id_mem_to_reg = t.mem_to_reg;
    id_branch     = t.branch;
  endtask

  task automatic fwd_off();
    mem_reg_write  = 1'b0;
    mem_rd         = '0;
    mem_alu_result = '0;
    wb_reg_write   = 1'b0;
    wb_rd          = '0;
    wb_data        = '0;
  endtask

  // ---------------- scoreboard ----------------
  // Expected EX-side view after a normal capture with no forwarding active.
  function automatic logic [EXP_W-1:0] expect_capture(input id_t t);
    logic       v;
    logic [4:0] wr;
    v  = t.valid;
    wr = t.reg_dst ? t.rd : t.rt;
    return {v, v & t.reg_write, v & t.mem_read, v & t.mem_write, v & t.mem_to_reg,
            v & t.branch, t.alu_ctrl, wr, t.rs_data,
            (t.alu_src ? t.imm : t.rt_data), t.rt_data, t.imm};
  endfunction

  function automatic logic [EXP_W-1:0] observed();
    return {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch,
            alu_control, ex_write_reg, alu_a, alu_b, ex_store_data, ex_imm};
  endfunction

  // Push the expectation when the ID instruction is driven, pop after the edge.
  task automatic capture(input id_t t, input string name);
    logic [EXP_W-1:0] exp_v;
    exp_q.push_back(expect_capture(t));
    apply_id(t);
    tick();
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      exp_v = exp_q.pop_front();
      if (observed() !== exp_v) begin
        bad++;
        $display("FAIL %s: got %h expected %h", name, observed(), exp_v);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    id_t t;
    total++;
    if ({ex_valid, ex_reg_write, ex_write_reg, alu_a, alu_b, ex_imm, stall} !== '0) begin
      bad++;
      $display("FAIL reset_initial: got %h expected 0",
               {ex_valid, ex_reg_write, ex_write_reg, alu_a, alu_b, ex_imm, stall});
    end
    rst_n = 1'b1;
    t = nop_id();
    t.valid = 1'b1; t.reg_write = 1'b1; t.rs_data = 32'h1234; t.rt_data = 32'h55;
    t.imm = 32'h9; t.rs = 5'd1; t.rt = 5'd2; t.rd = 5'd3; t.reg_dst = 1'b1; t.alu_ctrl = 1'b1;
    capture(t, "reset_precap");
    apply_id(nop_id());
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch,
         alu_control, ex_write_reg, alu_a, alu_b, ex_store_data, ex_imm, stall} !== '0) begin
      bad++;
      $display("FAIL reset_async: got %h expected 0",
               {ex_valid, ex_reg_write, alu_control, ex_write_reg, alu_a, alu_b, ex_imm, stall});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_plain_capture();
    id_t t;
    t = nop_id();
    t.valid = 1'b1; t.rs_data = 32'd5; t.rt_data = 32'd3; t.alu_ctrl = 1'b1;
    t.alu_src = 1'b0; t.reg_dst = 1'b1; t.rd = 5'd9; t.rs = 5'd1; t.rt = 5'd2;
    t.reg_write = 1'b1;
    capture(t, "plain_capture");
    total++;
    if (alu_a !== 32'd5 || alu_b !== 32'd3 || ex_write_reg !== 5'd9) begin
      bad++;
      $display("FAIL plain_fields: a=%0d b=%0d wr=%0d expected 5 3 9", alu_a, alu_b, ex_write_reg);
    end
  endtask

  task automatic test_back_to_back();
    id_t t;
    for (int i = 0; i < 24; i++) begin
      t = nop_id();
      t.valid      = 1'($urandom_range(0, 3) != 0);
      t.rs_data    = $urandom;
      t.rt_data    = $urandom;
      t.imm        = $urandom;
      t.rs         = 5'($urandom_range(0, 31));
      t.rt         = 5'($urandom_range(0, 31));
      t.rd         = 5'($urandom_range(0, 31));
      t.alu_src    = 1'($urandom_range(0, 1));
      t.alu_ctrl   = t.valid ? 1'($urandom_range(0, 1)) : 1'b0;
      t.reg_dst    = 1'($urandom_range(0, 1));
      t.reg_write  = 1'($urandom_range(0, 1));
      t.mem_write  = 1'($urandom_range(0, 1));
      t.mem_to_reg = 1'($urandom_range(0, 1));
      t.branch     = 1'($urandom_range(0, 1));
      t.mem_read   = 1'b0;  // loads are exercised separately
      capture(t, "b2b_random");
    end
  endtask

  task automatic test_forward_priority();
    id_t t;
    t = nop_id();
    t.valid = 1'b1; t.rs = 5'd4; t.rt = 5'd6; t.rs_data = 32'hAA; t.rt_data = 32'hBB;
    t.reg_write = 1'b1; t.rd = 5'd7; t.reg_dst = 1'b1;
    capture(t, "fwd_setup");
    apply_id(nop_id());
    mem_reg_write = 1'b1; mem_rd = 5'd4; mem_alu_result = 32'h11;
    wb_reg_write  = 1'b1; wb_rd  = 5'd4; wb_data        = 32'h22;
    #1;
    total++;
    if (alu_a !== 32'h11 || fwd_a_sel !== FWD_MEM || alu_b !== 32'hBB) begin
      bad++;
      $display("FAIL fwd_mem_first: a=%h sel=%0d b=%h expected 11 1 bb", alu_a, fwd_a_sel, alu_b);
    end
    mem_reg_write = 1'b0;
    #1;
    total++;
    if (alu_a !== 32'h22 || fwd_a_sel !== FWD_WB) begin
      bad++;
      $display("FAIL fwd_wb: a=%h sel=%0d expected 22 2", alu_a, fwd_a_sel);
    end
    wb_rd = 5'd6;
    #1;
    total++;
    if (alu_a !== 32'hAA || alu_b !== 32'h22 || fwd_b_sel !== FWD_WB) begin
      bad++;
      $display("FAIL fwd_rt_wb: a=%h b=%h sel=%0d expected aa 22 2", alu_a, alu_b, fwd_b_sel);
    end
    fwd_off();
    t = nop_id();
    t.valid = 1'b1; t.rs = 5'd0; t.rt = 5'd3; t.rs_data = 32'h33; t.rt_data = 32'h44;
    capture(t, "fwd_r0_setup");
    mem_reg_write = 1'b1; mem_rd = 5'd0; mem_alu_result = 32'h11;
    wb_reg_write  = 1'b1; wb_rd  = 5'd0; wb_data        = 32'h22;
    #1;
    total++;
    if (alu_a !== 32'h33 || fwd_a_sel !== FWD_REG) begin
      bad++;
      $display("FAIL fwd_r0: a=%h sel=%0d expected 33 0", alu_a, fwd_a_sel);
    end
    fwd_off();
  endtask

  task automatic test_load_use();
    id_t lw, add;
    lw = nop_id();
    lw.valid = 1'b1; lw.mem_read = 1'b1; lw.reg_write = 1'b1; lw.mem_to_reg = 1'b1;
    lw.rs = 5'd3; lw.rt = 5'd8; lw.alu_src = 1'b1; lw.imm = 32'd4; lw.rs_data = 32'd100;
    capture(lw, "lu_load");
    add = nop_id();
    add.valid = 1'b1; add.rs = 5'd8; add.rt = 5'd2; add.rd = 5'd10; add.reg_dst = 1'b1;
    add.reg_write = 1'b1; add.rs_data = 32'd7; add.rt_data = 32'd9;
    apply_id(add);
    #1;
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall_rs: stall=%b expected 1", stall); end
    tick();
    total++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL lu_bubble: valid=%b rw=%b stall=%b expected 0 0 0", ex_valid, ex_reg_write, stall);
    end
    capture(add, "lu_add_after");
    // rt compare is conservative
    capture(lw, "lu_load2");
    add.rs = 5'd1; add.rt = 5'd8;
    apply_id(add);
    #1;
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall_rt: stall=%b expected 1", stall); end
    // No stall when ID holds no instruction
    add.valid = 1'b0;
    apply_id(add);
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL lu_id_invalid: stall=%b expected 0", stall); end
    // A load to $0 never stalls
    lw.rt = 5'd0;
    capture(lw, "lu_load_r0");
    add = nop_id();
    add.valid = 1'b1; add.rs = 5'd0; add.rt = 5'd0;
    apply_id(add);
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL lu_r0: stall=%b expected 0", stall); end
  endtask

  task automatic test_flush();
    id_t lw, sw;
    lw = nop_id();
    lw.valid = 1'b1; lw.mem_read = 1'b1; lw.reg_write = 1'b1; lw.rt = 5'd5;
    capture(lw, "flush_load");
    sw = nop_id();
    sw.valid = 1'b1; sw.mem_write = 1'b1; sw.rs = 5'd5; sw.rt = 5'd6;
    apply_id(sw);
    flush = 1'b1;
    #1;
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL flush_stall_pre: stall=%b expected 1", stall); end
    tick();
    flush = 1'b0;
    total++;
    if (ex_valid !== 1'b0 || ex_mem_write !== 1'b0) begin
      bad++;
      $display("FAIL flush_and_stall: valid=%b mw=%b expected 0 0", ex_valid, ex_mem_write);
    end
    sw.reg_write = 1'b1; sw.branch = 1'b1;
    apply_id(sw);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++;
    if (ex_valid !== 1'b0 || ex_mem_write !== 1'b0 || ex_reg_write !== 1'b0 || ex_branch !== 1'b0) begin
      bad++;
      $display("FAIL flush_only: v=%b mw=%b rw=%b br=%b expected 0 0 0 0",
               ex_valid, ex_mem_write, ex_reg_write, ex_branch);
    end
  endtask

  task automatic test_imm_store();
    id_t t;
    t = nop_id();
    t.valid = 1'b1; t.mem_write = 1'b1; t.alu_src = 1'b1; t.imm = 32'hFFFF_FFFC;
    t.rs = 5'd2; t.rs_data = 32'h10; t.rt = 5'd7; t.rt_data = 32'h1;
    capture(t, "imm_setup");
    apply_id(nop_id());
    wb_reg_write = 1'b1; wb_rd = 5'd7; wb_data = 32'h77;
    #1;
    total++;
    if (alu_b !== 32'hFFFF_FFFC || ex_store_data !== 32'h77 || ex_imm !== 32'hFFFF_FFFC ||
        alu_a !== 32'h10) begin
      bad++;
      $display("FAIL imm_store: b=%h st=%h imm=%h a=%h expected fffffffc 77 fffffffc 10",
               alu_b, ex_store_data, ex_imm, alu_a);
    end
    fwd_off();
  endtask

  task automatic test_reset_mid_stall();
    id_t lw, add;
    lw = nop_id();
    lw.valid = 1'b1; lw.mem_read = 1'b1; lw.reg_write = 1'b1; lw.rt = 5'd8;
    capture(lw, "rms_load");
    add = nop_id();
    add.valid = 1'b1; add.rs = 5'd8; add.rt = 5'd1; add.rd = 5'd12; add.reg_dst = 1'b1;
    add.reg_write = 1'b1; add.rs_data = 32'h5A; add.rt_data = 32'hA5;
    apply_id(add);
    #1;
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL rms_pre: stall=%b expected 1", stall); end
    rst_n = 1'b0;
    #1;
    total++;
    if (stall !== 1'b0 || ex_valid !== 1'b0 || ex_mem_read !== 1'b0) begin
      bad++;
      $display("FAIL rms_reset: stall=%b v=%b mr=%b expected 0 0 0", stall, ex_valid, ex_mem_read);
    end
    rst_n = 1'b1;
    capture(add, "rms_add_after");
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    apply_id(nop_id());
    fwd_off();
    #2;
    @(posedge clk);
    #1;
    test_reset();
    test_plain_capture();
    test_back_to_back();
    test_forward_priority();
    test_load_use();
    test_flush();
    test_imm_store();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-delivery stage sitting directly upstream of the EX-stage ALU in the 5-stage MIPS pipeline.
- Captures decoded operands and control from ID each cycle.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards, then stalls ID and inserts a bubble.
- Drives the ALU operands (A, B, 1-bit add/sub control) and passes registered control and destination info on to EX/MEM.

Parameters:
DATA_W, 32, datapath width
REG_ADDR_W, 5, register-file address width

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs_data  in  DATA_W  register-file read port 1
id_rt_data  in  DATA_W  register-file read port 2
id_imm  in  DATA_W  sign-extended immediate
id_rs, id_rt, id_rd  in  REG_ADDR_W each  source/dest register numbers
id_alu_src  in  1  1 = B operand is immediate
id_alu_ctrl  in  1  0 = add, 1 = sub
id_reg_dst  in  1  1 = write rd, 0 = write rt
id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch  in  1 each  decoded control
flush  in  1  branch taken; kill the instruction entering EX
mem_reg_write  in  1  EX/MEM writes a register
mem_rd  in  REG_ADDR_W  EX/MEM destination
mem_alu_result  in  DATA_W  EX/MEM forwarded value
wb_reg_write  in  1  MEM/WB writes a register
wb_rd  in  REG_ADDR_W  MEM/WB destination
wb_data  in  DATA_W  MEM/WB forwarded value
stall  out  1  hold PC and IF/ID (combinational)
alu_a, alu_b  out  DATA_W each  ALU operands (combinational)
alu_control  out  1  registered ALU op
ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1 each  registered control to EX/MEM
ex_write_reg  out  REG_ADDR_W  selected destination (rd or rt)
ex_store_data  out  DATA_W  forwarded rt value for stores
ex_imm  out  DATA_W  registered immediate, for branch target

Behaviour:
- Reset: all registered state is 0 immediately on rst_n low. This covers controls, ex_valid, register numbers, data and imm. With no forwarding active, alu_a = alu_b = 0 and stall = 0.
- Latency: one cycle from ID inputs to registered outputs. alu_a, alu_b and ex_store_data are combinational from the registered state plus the forwarding inputs in the same cycle.
- Load-use stall:
  - stall = ex_valid & ex_mem_read & (ex_write_reg != 0) & id_valid & (ex_write_reg == id_rs | ex_write_reg == id_rt).
  - The rt compare is applied conservatively, even for I-type instructions.
- Per-edge register update, in priority order:
  - flush = 1: bubble (flush beats stall).
  - stall = 1: bubble.
  - otherwise: capture the ID fields; ex_valid <= id_valid.
- Bubble: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch <= 0. Datapath fields are still captured and are don't-care.
- If id_valid = 0 on a normal capture, all control bits are captured as 0.
- ex_write_reg <= id_reg_dst ? id_rd : id_rt.
- Forwarding, per source (rs for A, rt for B/store):
  - Priority 1: if mem_reg_write & mem_rd != 0 & mem_rd == src, use mem_alu_result.
  - Priority 2: else if wb_reg_write & wb_rd != 0 & wb_rd == src, use wb_data.
  - Otherwise use the registered register-file value.
  - Register 0 is never forwarded.
- alu_a = fwd_rs. alu_b = ex_alu_src ? ex_imm : fwd_rt. ex_store_data = fwd_rt regardless of alu_src.
- Forwarding is applied even when ex_valid = 0; the values are harmless because the controls are cleared.
- Reset mid-stall: state clears, stall drops immediately, no bubble is carried over.

Decomposition:
- Shared package mips_pkg: DATA_W/REG_ADDR_W constants; ALU_ADD = 1'b0, ALU_SUB = 1'b1; forwarding select encoding FWD_REG = 2'd0, FWD_MEM = 2'd1, FWD_WB = 2'd2.
- One sub-module: fwd_unit (purely combinational), instantiated twice (rs, rt). It returns the select plus the mux output.
- Hazard compare and pipeline register stay in id_ex_stage.

Test Plan:
- Reset: rst_n low mid-cycle with ex_reg_write = 1 -> all ex_* = 0 immediately, stall = 0, alu_a = alu_b = 0.
- Plain capture: id_rs_data = 5, id_rt_data = 3, alu_ctrl = 1, alu_src = 0, reg_dst = 1, rd = 9 -> next cycle alu_a = 5, alu_b = 3, alu_control = 1, ex_write_reg = 9.
- Forward priority: EX rs = 4; mem_rd = 4 / mem_alu_result = 0x11 and wb_rd = 4 / wb_data = 0x22 -> alu_a = 0x11. Drop mem_reg_write -> alu_a = 0x22. Set rs = 0 with mem_rd = 0 -> alu_a = registered value.
- Load-use: lw $8 in EX (mem_read = 1, ex_write_reg = 8), ID add with rs = 8 -> stall = 1; next cycle ex_valid = 0, ex_reg_write = 0. Then stall = 0 and the add captures normally.
- Flush with simultaneous stall: flush = 1 and stall = 1 -> bubble inserted, ex_mem_write = 0, ex_valid = 0.
- Immediate/store: alu_src = 1, imm = 0xFFFFFFFC, rt forwarded from wb = 0x77 -> alu_b = 0xFFFFFFFC, ex_store_data = 0x77.
